test_sweep_sequencer: RTL and testbench

//  Avalon-MM sequencer that runs multi-batch sweeps on the adder test control unit without CPU polling.
//  CPU programs base/length/batch count via slave port; block drives the control unit's register map
//  (0 go, 1 set_addr, 2 num, 3 pll_lock, 4 ID) through its master port. Per batch: set_addr, num, go=1, poll go until 0.

---
 rtl/test_sweep_sequencer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_test_sweep_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sweep_sequencer.sv
// Avalon-MM sweep sequencer: steps the adder test control unit through a series of
// batches (set_addr, num, go, poll go) with no CPU polling; abort and poll timeout supported.
module test_sweep_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int BATCH_W     = 8,
  parameter int TMO_DEFAULT = 65535
) (
  input  logic        avalon_clock,
  input  logic        resetn,
  input  logic [2:0]  s_address,
  input  logic        s_write,
  input  logic        s_read,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [2:0]  m_address,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        irq
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int TOT_W = ADDR_W + BATCH_W + 2;
  localparam logic [TOT_W-1:0] END_LIMIT = {{(TOT_W-ADDR_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0] TMO_RST = TMO_DEFAULT[15:0];

  localparam logic [1:0] EC_NONE   = 2'd0;
  localparam logic [1:0] EC_CONFIG = 2'd1;
  localparam logic [1:0] EC_PLL    = 2'd2;
  localparam logic [1:0] EC_TMO    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOCK_RD,
    S_LOCK_WT,
    S_WR_ADDR,
    S_WR_NUM,
    S_WR_GO,
    S_POLL_RD,
    S_POLL_WT,
    S_NEXT,
    S_ABORT_WR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [BATCH_W-1:0] batches_q, batches_d;
  logic [BATCH_W-1:0] progress_q, progress_d;
  logic [15:0]        timeout_q, timeout_d;
  logic [1:0]         errcode_q, errcode_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;
  logic               irq_en_q, irq_en_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [31:0]        rdata_q;
  logic [31:0]        rd_mux;

  logic               busy;
  logic               ctrl_wr;
  logic               cfg_wr;
  logic               start_cmd;
  logic               abort_cmd;
  logic               abort_hit;
  logic               cfg_bad;
  logic [TOT_W-1:0]   base_ext, len_ext, batches_ext, sweep_end;
  logic [LEN_W-1:0]   set_addr;
  logic [LEN_W-1:0]   num_val;
  logic [BATCH_W-1:0] progress_inc;
  logic [16:0]        tmo_next;
  logic               timed_out;
  logic               unused_bits;

  assign busy      = (state_q != S_IDLE);
  assign ctrl_wr   = s_write && (s_address == 3'd0);
  assign cfg_wr    = s_write && !busy;
  assign start_cmd = ctrl_wr && s_writedata[0];
  assign abort_cmd = ctrl_wr && s_writedata[1];
  assign abort_hit = abort_cmd && busy && (state_q != S_ABORT_WR);

  // The end-of-sweep check is a one-off at start; batch addresses use the running accumulator.
  assign base_ext    = {{(TOT_W-ADDR_W){1'b0}}, base_q};
  assign len_ext     = {{(TOT_W-LEN_W){1'b0}}, len_q};
  assign batches_ext = {{(TOT_W-BATCH_W){1'b0}}, batches_q};
  assign sweep_end   = base_ext + batches_ext * len_ext;
  assign cfg_bad     = (len_q == '0) || (batches_q == '0) || (sweep_end > END_LIMIT);

  assign set_addr     = {1'b0, base_q} + acc_q;
  assign num_val      = set_addr + len_q;
  assign progress_inc = progress_q + {{(BATCH_W-1){1'b0}}, 1'b1};
  assign tmo_next     = {1'b0, tmo_cnt_q} + 17'd1;
  assign timed_out    = (tmo_next >= {1'b0, timeout_q});

  assign irq         = irq_en_q && (done_q || err_q);
  assign s_readdata  = rdata_q;
  assign unused_bits = ^{s_writedata[31:16], m_readdata[31:1]};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    batches_d  = batches_q;
    progress_d = progress_q;
    timeout_d  = timeout_q;
    errcode_d  = errcode_q;
    done_d     = done_q;
    err_d      = err_q;
    aborted_d  = aborted_q;
    irq_en_d   = irq_en_q;
    acc_d      = acc_q;
    tmo_cnt_d  = tmo_cnt_q;
    m_address   = 3'd0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_writedata = 32'd0;

    case (state_q)
      S_LOCK_RD: begin
        m_read    = 1'b1;
        m_address = 3'd3;
      end
      S_WR_ADDR: begin
        m_write     = 1'b1;
        m_address   = 3'd1;
        m_writedata = {{(32-LEN_W){1'b0}}, set_addr};
      end
      S_WR_NUM: begin
        m_write     = 1'b1;
        m_address   = 3'd2;
        m_writedata = {{(32-LEN_W){1'b0}}, num_val};
      end
      S_WR_GO: begin
        m_write     = 1'b1;
        m_address   = 3'd0;
        m_writedata = 32'd1;
      end
      S_POLL_RD: begin
        m_read    = 1'b1;
        m_address = 3'd0;
      end
      S_ABORT_WR: begin
        m_write   = 1'b1;
        m_address = 3'd0;
      end
      default: ;
    endcase

    if (cfg_wr) begin
      case (s_address)
        3'd1: base_d    = s_writedata[ADDR_W-1:0];
        3'd2: len_d     = s_writedata[LEN_W-1:0];
        3'd3: batches_d = s_writedata[BATCH_W-1:0];
        3'd5: timeout_d = s_writedata[15:0];
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      irq_en_d = s_writedata[2];
      if (s_writedata[3]) begin
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        errcode_d = EC_NONE;
      end
    end

    // Every state is a single cycle, so redirecting here never cuts a strobe short.
    if (abort_hit) begin
      state_d   = S_ABORT_WR;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_cmd && !abort_cmd) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            aborted_d  = 1'b0;
            errcode_d  = EC_NONE;
            progress_d = '0;
            acc_d      = '0;
            if (cfg_bad) begin
              err_d     = 1'b1;
              errcode_d = EC_CONFIG;
            end else begin
              state_d = S_LOCK_RD;
            end
          end
        end
        S_LOCK_RD: state_d = S_LOCK_WT;
        S_LOCK_WT: begin
          if (m_readdata[0]) begin
            state_d = S_WR_ADDR;
          end else begin
            err_d     = 1'b1;
            errcode_d = EC_PLL;
            state_d   = S_IDLE;
          end
        end
        S_WR_ADDR: state_d = S_WR_NUM;
        S_WR_NUM:  state_d = S_WR_GO;
        S_WR_GO: begin
          tmo_cnt_d = '0;
          state_d   = S_POLL_RD;
        end
        S_POLL_RD: begin
          tmo_cnt_d = tmo_next[15:0];
          if (timed_out) begin
            err_d     = 1'b1;
            errcode_d = EC_TMO;
            state_d   = S_ABORT_WR;
          end else begin
            state_d = S_POLL_WT;
          end
        end
        S_POLL_WT: begin
          tmo_cnt_d = tmo_next[15:0];
          // A unit that has just gone idle counts as finished even on the timeout cycle.
          if (!m_readdata[0]) begin
            state_d = S_NEXT;
          end else if (timed_out) begin
            err_d     = 1'b1;
            errcode_d = EC_TMO;
            state_d   = S_ABORT_WR;
          end else begin
            state_d = S_POLL_RD;
          end
        end
        S_NEXT: begin
          progress_d = progress_inc;
          acc_d      = acc_q + len_q;
          if (progress_inc == batches_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WR_ADDR;
          end
        end
        S_ABORT_WR: state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (s_address)
      3'd0: rd_mux = {27'd0, irq_en_q, aborted_q, err_q, done_q, busy};
      3'd1: rd_mux = {{(32-ADDR_W){1'b0}}, base_q};
      3'd2: rd_mux = {{(32-LEN_W){1'b0}}, len_q};
      3'd3: rd_mux = {{(32-BATCH_W){1'b0}}, batches_q};
      3'd4: rd_mux = {{(32-BATCH_W){1'b0}}, progress_q};
      3'd5: rd_mux = {16'd0, timeout_q};
      3'd6: rd_mux = {30'd0, errcode_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      batches_q  <= '0;
      progress_q <= '0;
      timeout_q  <= TMO_RST;
      errcode_q  <= EC_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      acc_q      <= '0;
      tmo_cnt_q  <= '0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      batches_q  <= batches_d;
      progress_q <= progress_d;
      timeout_q  <= timeout_d;
      errcode_q  <= errcode_d;
      done_q     <= done_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
      irq_en_q   <= irq_en_d;
      acc_q      <= acc_d;
      tmo_cnt_q  <= tmo_cnt_d;
      if (s_read) begin
        rdata_q <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_test_sweep_sequencer.sv
// Directed bench: register table, then sweep, bad config, pll unlock, timeout, abort
// and mid-operation reset, against a small model of the control unit.
module tb_test_sweep_sequencer;

  logic        avalon_clock;
  logic        resetn;
  logic [2:0]  s_address;
  logic        s_write;
  logic        s_read;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [2:0]  m_address;
  logic        m_write;
  logic        m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        irq;

  test_sweep_sequencer #(.ADDR_W(11), .BATCH_W(8), .TMO_DEFAULT(65535)) dut (
    .avalon_clock(avalon_clock),
    .resetn(resetn),
    .s_address(s_address),
    .s_write(s_write),
    .s_read(s_read),
    .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .m_address(m_address),
    .m_write(m_write),
    .m_read(m_read),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .irq(irq)
  );

  initial avalon_clock = 1'b0;
  always #5 avalon_clock = ~avalon_clock;

  // Control-unit model: go self-clears go_drop_after cycles after being set (never if < 0).
  logic [2:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          wr_cyc_log[$];
  int          cyc = 0;
  int          rd_count = 0;
  int          lock_rd_count = 0;
  logic        go_q = 1'b0;
  int          go_age = 0;
  int          go_drop_after = 20;
  logic        pll_lock = 1'b1;

  initial m_readdata = 32'd0;

  always @(posedge avalon_clock) begin
    cyc <= cyc + 1;
    if (m_write) begin
      wr_addr_log.push_back(m_address);
      wr_data_log.push_back(m_writedata);
      wr_cyc_log.push_back(cyc);
      if (m_address == 3'd0) begin
        go_q   <= m_writedata[0];
        go_age <= 0;
      end
    end else if (go_q) begin
      go_age <= go_age + 1;
      if (go_drop_after >= 0 && go_age + 1 >= go_drop_after) go_q <= 1'b0;
    end
    if (m_read) begin
      rd_count <= rd_count + 1;
      if (m_address == 3'd3) lock_rd_count <= lock_rd_count + 1;
      case (m_address)
        3'd0:    m_readdata <= {31'd0, go_q};
        3'd3:    m_readdata <= {31'd0, pll_lock};
        default: m_readdata <= 32'd0;
      endcase
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("check %-22s got 0x%08h ok", name, act);
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge avalon_clock);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    @(negedge avalon_clock);
    s_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge avalon_clock);
    s_address = a;
    s_read    = 1'b1;
    @(negedge avalon_clock);
    s_read    = 1'b0;
    d         = s_readdata;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input int max_reads, input string name);
    logic [31:0] d;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_reads; i++) begin
      csr_read(3'd0, d);
      if (!d[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge avalon_clock);
      if (wr_addr_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct packed {
    logic        do_wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int b;
    int rb;
    int lb;
    bit found;
    logic [31:0] d;

    vecs[0]  = '{1'b0, 3'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0,         32'h0000_ffff};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 3'd1, 32'hffff_ffff, 32'h0000_07ff};
    vecs[8]  = '{1'b1, 3'd2, 32'hffff_ffff, 32'h0000_0fff};
    vecs[9]  = '{1'b1, 3'd3, 32'hffff_ffff, 32'h0000_00ff};
    vecs[10] = '{1'b1, 3'd5, 32'h0001_2345, 32'h0000_2345};
    vecs[11] = '{1'b1, 3'd0, 32'h0000_0004, 32'h0000_0010};
    vecs[12] = '{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{1'b1, 3'd5, 32'h0000_ffff, 32'h0000_ffff};
    vecs[14] = '{1'b0, 3'd7, 32'h0,         32'h0};

    resetn = 1'b0;
    s_address = 3'd0;
    s_write = 1'b0;
    s_read = 1'b0;
    s_writedata = 32'd0;
    repeat (3) @(negedge avalon_clock);
    check("reset_m_write", 32'(m_write), 32'd0);
    check("reset_m_read", 32'(m_read), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_wr) csr_write(vecs[i].addr, vecs[i].wdata);
      check_reg($sformatf("vec%0d_reg%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // Four-batch sweep
    pll_lock = 1'b1;
    go_drop_after = 20;
    csr_write(3'd1, 32'd0);
    csr_write(3'd2, 32'd16);
    csr_write(3'd3, 32'd4);
    b = wr_addr_log.size();
    lb = lock_rd_count;
    csr_write(3'd0, 32'h1);
    wait_idle(400, "sweep_finishes");
    check("sweep_nwrites", 32'(wr_addr_log.size() - b), 32'd12);
    if (wr_addr_log.size() - b == 12) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("sweep_b%0d_addr_reg", k), 32'(wr_addr_log[b + 3*k]), 32'd1);
        check($sformatf("sweep_b%0d_set_addr", k), wr_data_log[b + 3*k], 32'(16*k));
        check($sformatf("sweep_b%0d_num_reg", k), 32'(wr_addr_log[b + 3*k + 1]), 32'd2);
        check($sformatf("sweep_b%0d_num", k), wr_data_log[b + 3*k + 1], 32'(16*k + 16));
        check($sformatf("sweep_b%0d_go", k), wr_data_log[b + 3*k + 2], 32'd1);
      end
    end
    check("sweep_lock_reads", 32'(lock_rd_count - lb), 32'd1);
    check_reg("sweep_ctrl_done", 3'd0, 32'h02);
    check_reg("sweep_progress", 3'd4, 32'd4);
    check("sweep_irq_disabled", 32'(irq), 32'd0);

    // Config overruns the RAM end; irq enabled to see the level and its clear
    csr_write(3'd1, 32'd2040);
    csr_write(3'd3, 32'd1);
    b = wr_addr_log.size();
    rb = rd_count;
    csr_write(3'd0, 32'h5);
    repeat (10) @(negedge avalon_clock);
    check("badcfg_writes", 32'(wr_addr_log.size() - b), 32'd0);
    check("badcfg_reads", 32'(rd_count - rb), 32'd0);
    check("badcfg_irq", 32'(irq), 32'd1);
    check_reg("badcfg_ctrl", 3'd0, 32'h14);
    check_reg("badcfg_errcode", 3'd6, 32'd1);
    check_reg("badcfg_progress", 3'd4, 32'd0);
    csr_write(3'd0, 32'hc);
    check("clr_irq_low", 32'(irq), 32'd0);
    check_reg("clr_ctrl", 3'd0, 32'h10);

    // PLL unlocked
    pll_lock = 1'b0;
    csr_write(3'd1, 32'd0);
    b = wr_addr_log.size();
    lb = lock_rd_count;
    rb = rd_count;
    csr_write(3'd0, 32'h1);
    wait_idle(20, "pll_finishes");
    check("pll_lock_reads", 32'(lock_rd_count - lb), 32'd1);
    check("pll_total_reads", 32'(rd_count - rb), 32'd1);
    check("pll_writes", 32'(wr_addr_log.size() - b), 32'd0);
    check_reg("pll_ctrl", 3'd0, 32'h04);
    check_reg("pll_errcode", 3'd6, 32'd2);

    // Poll timeout with go stuck high
    pll_lock = 1'b1;
    go_drop_after = -1;
    csr_write(3'd5, 32'd100);
    b = wr_addr_log.size();
    csr_write(3'd0, 32'h1);
    wait_idle(200, "tmo_finishes");
    check("tmo_nwrites", 32'(wr_addr_log.size() - b), 32'd4);
    if (wr_addr_log.size() - b == 4) begin
      check("tmo_abort_addr", 32'(wr_addr_log[b + 3]), 32'd0);
      check("tmo_abort_data", wr_data_log[b + 3], 32'd0);
      check("tmo_delay_near_100",
            32'((wr_cyc_log[b + 3] - wr_cyc_log[b + 2] >= 98) &&
                (wr_cyc_log[b + 3] - wr_cyc_log[b + 2] <= 104)), 32'd1);
    end
    check_reg("tmo_ctrl", 3'd0, 32'h04);
    check_reg("tmo_errcode", 3'd6, 32'd3);

    // Abort while polling the second batch; config writes and start are ignored while busy
    go_drop_after = 20;
    csr_write(3'd5, 32'hffff);
    csr_write(3'd3, 32'd4);
    b = wr_addr_log.size();
    csr_write(3'd0, 32'h1);
    wait_writes(b + 6, 200, "abort_reach_batch2");
    repeat (3) @(negedge avalon_clock);
    csr_write(3'd1, 32'd100);
    csr_write(3'd0, 32'h1);
    csr_write(3'd0, 32'h2);
    wait_idle(20, "abort_finishes");
    check("abort_nwrites", 32'(wr_addr_log.size() - b), 32'd7);
    check("abort_last_addr", 32'(wr_addr_log[wr_addr_log.size() - 1]), 32'd0);
    check("abort_last_data", wr_data_log[wr_data_log.size() - 1], 32'd0);
    check_reg("abort_ctrl", 3'd0, 32'h08);
    check_reg("abort_progress", 3'd4, 32'd1);
    check_reg("abort_base_kept", 3'd1, 32'd0);
    check_reg("abort_errcode", 3'd6, 32'd0);
    csr_write(3'd0, 32'h8);
    check_reg("abort_clr_ctrl", 3'd0, 32'h00);

    // Sweep ending exactly at the RAM end, reset while in WR_NUM
    csr_write(3'd5, 32'd500);
    csr_write(3'd1, 32'd2032);
    csr_write(3'd2, 32'd16);
    csr_write(3'd3, 32'd1);
    csr_write(3'd0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge avalon_clock);
      if (m_write && m_address == 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("edge_wr_addr_seen", 32'(found), 32'd1);
    check("edge_set_addr", m_writedata, 32'd2032);
    @(negedge avalon_clock);
    check("edge_num_reg", 32'(m_address), 32'd2);
    check("edge_num", m_writedata, 32'd2048);
    resetn = 1'b0;
    @(negedge avalon_clock);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    resetn = 1'b1;
    check_reg("rst_ctrl", 3'd0, 32'h0);
    check_reg("rst_base", 3'd1, 32'h0);
    check_reg("rst_len", 3'd2, 32'h0);
    check_reg("rst_timeout", 3'd5, 32'hffff);
    d = 32'd0;
    repeat (5) @(negedge avalon_clock);
    check("rst_stays_quiet", 32'(m_write | m_read), d);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
